fsb8_target: RTL and testbench
==============================

Name: fsb8_target

Overview:
Peripheral-side endpoint of the FSB8 bus: sits directly downstream of the FSB8 master bridge on the board/package boundary. It decodes the frames the master drives (command, address, turnaround, read/write data, burst) and converts them into single-beat accesses on a simple local register/memory port. It returns rdy_n/err_n handshakes and read data on AD, and forwards peripheral interrupts as irq_n.

Parameters:
PAE_ENABLE, 1'b0, 1 = command 8'h00 loads page register addr[31:24]; 0 = page forced to 0.
ADDR_WIDTH, (PAE_ENABLE)?32:24, width of lcl_addr.
TIMEOUT, 7'd64, lcl_ack wait limit in cycles per beat; 0 disables the timeout.
IRQ_NUM, 4, number of local interrupt sources.

Ports:
clk  in  1  bus clock (FSB8 clk).
rst  in  1  asynchronous, active-high reset.
ale_n  in  1  address frame strobe.
cs_n  in  1  data frame select.
cmd_n  in  1  command frame strobe.
typ  in  1  0 single, 1 burst (informational; copied to lcl_burst).
wr_n  in  1  write data frame.
AAH8  in  8  page (cmd), addr[23:16] (ale), addr[7:0] (data).
AD_in  in  8  cmd code (cmd), addr[15:8] (ale), write data (write).
AD_out  out  8  read data to master.
AD_oe  out  1  1 = drive AD_out on the pins.
rdy_n  out  1  frame/beat complete, active low.
err_n  out  1  beat error, active low, valid with rdy_n.
irq_n  out  1  OR of irq_src, active low.
lcl_addr  out  ADDR_WIDTH  {page, hi16, lo8}.
lcl_wr  out  1  write request, held until lcl_ack.
lcl_rd  out  1  read request, held until lcl_ack.
lcl_wdata  out  8  write data.
lcl_burst  out  1  typ sampled at beat start.
lcl_rdata  in  8  read data, valid with lcl_ack.
lcl_ack  in  1  access done.
lcl_err  in  1  access failed, valid with lcl_ack.
cmd_valid  out  1  one-cycle pulse for a non-zero command.
cmd_code  out  8  command byte, valid with cmd_valid.
irq_src  in  IRQ_NUM  level interrupt sources.

Behaviour:
- Reset: state IDLE; rdy_n=1, err_n=1, irq_n=1, AD_out=0, AD_oe=0, lcl_wr=lcl_rd=0, lcl_addr=0, page=0, cmd_valid=0, timeout counter=0. Reset mid-access drops lcl_wr/lcl_rd immediately.
- All outputs registered; rdy_n low for exactly one cycle per acknowledged frame/beat.
- States: IDLE, CMD_ACK, ADR_ACK, SEL, ACCESS, BEAT_ACK.
- IDLE: cmd_n=0 -> latch AD_in, AAH8 -> CMD_ACK. ale_n=0 -> latch hi16={AAH8,AD_in} -> ADR_ACK. cmd_n and ale_n both low -> command wins. cs_n=0 in IDLE is ignored (no access).
- CMD_ACK: rdy_n=0 one cycle. Code 8'h00 with PAE_ENABLE=1 -> page<=AAH8. Non-zero code -> cmd_valid pulse, cmd_code=code. Next state IDLE.
- ADR_ACK: rdy_n=0 one cycle -> SEL with first_beat=1.
- SEL: cs_n=0 -> capture lo8=AAH8; wr_n=0 -> lcl_wr, lcl_wdata=AD_in; wr_n=1 -> lcl_rd. lcl_burst=typ -> ACCESS. All strobes high and first_beat=1 -> turnaround (dummy) frame: rdy_n=0 one cycle, stay SEL. All high and first_beat=0 -> IDLE. ale_n=0 -> re-address (ADR_ACK). cmd_n=0 -> command frame as in IDLE.
- ACCESS: hold request and lcl_addr stable until lcl_ack. On ack: drop request; err_n=~lcl_err; on read AD_out=lcl_rdata -> BEAT_ACK.
- Timeout: counter increments in ACCESS. When it reaches TIMEOUT, drop request, err_n=0, AD_out=8'hFF -> BEAT_ACK. A lcl_ack arriving in the same cycle takes priority over the timeout.
- BEAT_ACK: rdy_n=0 and err_n valid one cycle; first_beat<=0 -> SEL. Burst beats repeat SEL->ACCESS->BEAT_ACK, taking a new lo8 from AAH8 each beat.
- AD_oe=1 only in ACCESS/BEAT_ACK of a read. It drops the cycle after BEAT_ACK, so AD_oe is never high while the master drives AD (cmd/ale/write frames).
- irq_n = ~|irq_src, registered (1-cycle latency).

Test Plan:
- ale_n=0 with AAH8=8'h12, AD_in=8'h34; dummy frame; cs_n=0, wr_n=1, AAH8=8'h56; lcl_ack after 3 cycles with rdata 8'hA5 -> lcl_addr=24'h123456, lcl_rd high 3 cycles, rdy_n low 1 cycle with AD_out=8'hA5, AD_oe=1, err_n=1.
- Write single: addr 24'h00FF10, data 8'h5A, immediate ack -> lcl_wr 1 cycle, lcl_wdata=8'h5A, one rdy_n pulse, back to IDLE when cs_n rises.
- PAE_ENABLE=1: cmd_n=0, AD_in=8'h00, AAH8=8'h80, then write 24'h000001 -> lcl_addr=32'h80000001, cmd_valid stays 0. Next cmd 8'h3C -> cmd_valid pulse, cmd_code=8'h3C.
- Burst write 4 beats, typ=1, lo8 8'h00..8'h03 -> 4 lcl_wr with lcl_burst=1, 4 rdy_n pulses, addresses increment in lo8 only.
- Read with no lcl_ack, TIMEOUT=64 -> request dropped at cycle 64, rdy_n and err_n low together, AD_out=8'hFF. Repeat with lcl_ack+lcl_err in the same cycle -> err_n low, AD_out=lcl_rdata.
- Assert rst during ACCESS -> lcl_rd=0, rdy_n=1, AD_oe=0 immediately; state IDLE. irq_src=4'b0100 -> irq_n low the next cycle.

Source files
------------

// File: rtl/fsb8_target.sv
// FSB8 peripheral endpoint: decodes command/address/data frames from the master
// bridge into single-beat local accesses and returns rdy_n/err_n, read data and irq_n.
module fsb8_target #(
    parameter logic       PAE_ENABLE = 1'b0,
    parameter int         ADDR_WIDTH = PAE_ENABLE ? 32 : 24,
    parameter logic [6:0] TIMEOUT    = 7'd64,
    parameter int         IRQ_NUM    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ale_n,
    input  logic                  cs_n,
    input  logic                  cmd_n,
    input  logic                  typ,
    input  logic                  wr_n,
    input  logic [7:0]            AAH8,
    input  logic [7:0]            AD_in,
    output logic [7:0]            AD_out,
    output logic                  AD_oe,
    output logic                  rdy_n,
    output logic                  err_n,
    output logic                  irq_n,
    output logic [ADDR_WIDTH-1:0] lcl_addr,
    output logic                  lcl_wr,
    output logic                  lcl_rd,
    output logic [7:0]            lcl_wdata,
    output logic                  lcl_burst,
    input  logic [7:0]            lcl_rdata,
    input  logic                  lcl_ack,
    input  logic                  lcl_err,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_code,
    input  logic [IRQ_NUM-1:0]    irq_src
);

    typedef enum logic [2:0] {IDLE, CMD_ACK, ADR_ACK, SEL, ACCESS, BEAT_ACK} state_t;

    state_t                state_q;
    logic                  rdy_n_q, err_n_q, irq_n_q, ad_oe_q;
    logic [7:0]            ad_out_q;
    logic                  lcl_wr_q, lcl_rd_q, lcl_burst_q;
    logic [ADDR_WIDTH-1:0] lcl_addr_q;
    logic [7:0]            lcl_wdata_q;
    logic                  cmd_valid_q;
    logic [7:0]            cmd_code_q;
    logic [7:0]            page_q;
    logic [15:0]           hi16_q;
    logic                  first_beat_q;
    logic [6:0]            cnt_q;
    logic [6:0]            cnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    assign cnt_d = cnt_q + 7'd1;

    // The page byte only exists on the local address when the port is wider than 24 bits.
    if (ADDR_WIDTH > 24) begin : g_page
        assign addr_d = {page_q[ADDR_WIDTH-25:0], hi16_q, AAH8};
    end else begin : g_nopage
        logic unused_page;
        assign unused_page = ^page_q;
        assign addr_d      = {hi16_q, AAH8};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rdy_n_q      <= 1'b1;
            err_n_q      <= 1'b1;
            irq_n_q      <= 1'b1;
            ad_oe_q      <= 1'b0;
            ad_out_q     <= 8'h00;
            lcl_wr_q     <= 1'b0;
            lcl_rd_q     <= 1'b0;
            lcl_burst_q  <= 1'b0;
            lcl_addr_q   <= '0;
            lcl_wdata_q  <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 8'h00;
            page_q       <= 8'h00;
            hi16_q       <= 16'h0000;
            first_beat_q <= 1'b0;
            cnt_q        <= 7'd0;
        end else begin
            rdy_n_q     <= 1'b1;
            err_n_q     <= 1'b1;
            cmd_valid_q <= 1'b0;
            irq_n_q     <= ~|irq_src;
            case (state_q)
                IDLE, SEL: begin
                    // While our own ack is on the pins the master has not reacted yet,
                    // so the strobes sampled in that cycle are stale and are skipped.
                    if (rdy_n_q) begin
                        if (!cmd_n) begin
                            cmd_code_q  <= AD_in;
                            cmd_valid_q <= |AD_in;
                            if (PAE_ENABLE && AD_in == 8'h00) page_q <= AAH8;
                            rdy_n_q     <= 1'b0;
                            state_q     <= CMD_ACK;
                        end else if (!ale_n) begin
                            hi16_q  <= {AAH8, AD_in};
                            rdy_n_q <= 1'b0;
                            state_q <= ADR_ACK;
                        end else if (state_q == SEL) begin
                            if (!cs_n) begin
                                lcl_addr_q  <= addr_d;
                                lcl_burst_q <= typ;
                                cnt_q       <= 7'd0;
                                if (!wr_n) begin
                                    lcl_wr_q    <= 1'b1;
                                    lcl_wdata_q <= AD_in;
                                end else begin
                                    lcl_rd_q <= 1'b1;
                                    ad_oe_q  <= 1'b1;
                                end
                                state_q <= ACCESS;
                            end else if (first_beat_q) begin
                                rdy_n_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                CMD_ACK: state_q <= IDLE;
                ADR_ACK: begin
                    first_beat_q <= 1'b1;
                    state_q      <= SEL;
                end
                ACCESS: begin
                    if (lcl_ack) begin
                        lcl_wr_q <= 1'b0;
                        lcl_rd_q <= 1'b0;
                        rdy_n_q  <= 1'b0;
                        err_n_q  <= ~lcl_err;
                        if (lcl_rd_q) ad_out_q <= lcl_rdata;
                        state_q  <= BEAT_ACK;
                    end else if (TIMEOUT != 7'd0 && cnt_d == TIMEOUT) begin
                        lcl_wr_q <= 1'b0;
                        lcl_rd_q <= 1'b0;
                        rdy_n_q  <= 1'b0;
                        err_n_q  <= 1'b0;
                        ad_out_q <= 8'hFF;
                        state_q  <= BEAT_ACK;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                BEAT_ACK: begin
                    ad_oe_q      <= 1'b0;
                    first_beat_q <= 1'b0;
                    state_q      <= SEL;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign AD_out    = ad_out_q;
    assign AD_oe     = ad_oe_q;
    assign rdy_n     = rdy_n_q;
    assign err_n     = err_n_q;
    assign irq_n     = irq_n_q;
    assign lcl_addr  = lcl_addr_q;
    assign lcl_wr    = lcl_wr_q;
    assign lcl_rd    = lcl_rd_q;
    assign lcl_wdata = lcl_wdata_q;
    assign lcl_burst = lcl_burst_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;

endmodule

// File: tb/tb_fsb8_target.sv
// Directed bench for fsb8_target: bus-master tasks push expected handshakes, a
// local-side responder acks accesses, and monitors pop and compare as outputs appear.
module tb_fsb8_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        ale_n, cs_n, cmd_n, typ, wr_n;
    logic [7:0]  AAH8, AD_in, AD_out;
    logic        AD_oe, rdy_n, err_n, irq_n;
    logic [31:0] lcl_addr;
    logic        lcl_wr, lcl_rd, lcl_burst, lcl_ack, lcl_err;
    logic [7:0]  lcl_wdata, lcl_rdata, cmd_code;
    logic        cmd_valid;
    logic [3:0]  irq_src;

    always #5 clk = ~clk;

    fsb8_target #(
        .PAE_ENABLE(1'b1),
        .ADDR_WIDTH(32),
        .TIMEOUT   (7'd64),
        .IRQ_NUM   (4)
    ) dut (
        .clk(clk), .rst(rst), .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .typ(typ),
        .wr_n(wr_n), .AAH8(AAH8), .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe),
        .rdy_n(rdy_n), .err_n(err_n), .irq_n(irq_n), .lcl_addr(lcl_addr),
        .lcl_wr(lcl_wr), .lcl_rd(lcl_rd), .lcl_wdata(lcl_wdata), .lcl_burst(lcl_burst),
        .lcl_rdata(lcl_rdata), .lcl_ack(lcl_ack), .lcl_err(lcl_err),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .irq_src(irq_src)
    );

    typedef struct {
        logic       err_n;
        logic       oe;
        logic [7:0] ad;
        bit         chk_ad;
    } rdy_exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        burst;
        int          dur;
    } lcl_exp_t;

    rdy_exp_t   rdy_q[$];
    lcl_exp_t   lcl_q[$];
    logic [7:0] cmd_q[$];
    int checks = 0;
    int errors = 0;

    // Responder configuration; ack_delay == 0 means never acknowledge.
    int         ack_delay = 1;
    logic       ack_err   = 1'b0;
    logic [7:0] rdata_cfg = 8'h00;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_rdy(input logic e, input logic oe, input logic [7:0] ad, input bit chk);
        rdy_exp_t r;
        r.err_n = e; r.oe = oe; r.ad = ad; r.chk_ad = chk;
        rdy_q.push_back(r);
    endfunction

    function automatic void push_lcl(input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                                     input logic burst, input int dur);
        lcl_exp_t l;
        l.wr = wr; l.addr = addr; l.wdata = wd; l.burst = burst; l.dur = dur;
        lcl_q.push_back(l);
    endfunction

    task automatic set_idle();
        cmd_n = 1'b1; ale_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_rdy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!rdy_n) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: rdy_n stayed high for 200 cycles, required a low pulse", name);
        end
    endtask

    task automatic cmd_frame(input logic [7:0] code, input logic [7:0] pg);
        cmd_n = 1'b0; AD_in = code; AAH8 = pg;
        push_rdy(1'b1, 1'b0, 8'h00, 1'b0);
        if (code != 8'h00) cmd_q.push_back(code);
        wait_rdy("cmd_frame");
        set_idle();
    endtask

    task automatic addr_frame(input logic [7:0] hi, input logic [7:0] mid);
        ale_n = 1'b0; AAH8 = hi; AD_in = mid;
        push_rdy(1'b1, 1'b0, 8'h00, 1'b0);
        wait_rdy("addr_frame");
        set_idle();
    endtask

    task automatic dummy_frame();
        set_idle();
        push_rdy(1'b1, 1'b0, 8'h00, 1'b0);
        wait_rdy("dummy_frame");
    endtask

    task automatic beat(input bit wr, input logic [7:0] lo, input logic [7:0] wd, input logic t,
                        input logic [31:0] exp_addr, input int dur, input logic exp_err_n,
                        input logic [7:0] exp_ad);
        cs_n = 1'b0; wr_n = ~wr; AAH8 = lo; AD_in = wd; typ = t;
        push_lcl(wr, exp_addr, wd, t, dur);
        push_rdy(exp_err_n, ~wr, exp_ad, ~wr);
        wait_rdy("beat");
    endtask

    task automatic end_access();
        set_idle();
        repeat (3) @(negedge clk);
    endtask

    // Local-side responder: acks on the ack_delay-th cycle of a request.
    initial begin : responder
        int rcnt;
        rcnt = 0; lcl_ack = 1'b0; lcl_err = 1'b0; lcl_rdata = 8'h00;
        forever begin
            @(negedge clk);
            lcl_rdata = rdata_cfg;
            if (rst || !(lcl_rd || lcl_wr)) begin
                rcnt = 0; lcl_ack = 1'b0; lcl_err = 1'b0;
            end else begin
                rcnt++;
                if (ack_delay != 0 && rcnt == ack_delay) begin
                    lcl_ack = 1'b1; lcl_err = ack_err;
                end else begin
                    lcl_ack = 1'b0; lcl_err = 1'b0;
                end
            end
        end
    end

    initial begin : mon_rdy
        rdy_exp_t e;
        bit       oe_chk;
        oe_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (oe_chk) begin
                check("ad_oe_drop", AD_oe, 1'b0);
                oe_chk = 1'b0;
            end
            if (!rst && !rdy_n) begin
                if (rdy_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rdy_unexpected: got rdy_n=0 expected no ack");
                end else begin
                    e = rdy_q.pop_front();
                    check("err_n", err_n, e.err_n);
                    check("ad_oe", AD_oe, e.oe);
                    if (e.chk_ad) check("ad_out", AD_out, e.ad);
                    $display("ack: err_n=%b ad_oe=%b ad_out=%h", err_n, AD_oe, AD_out);
                    oe_chk = 1'b1;
                end
            end
        end
    end

    initial begin : mon_lcl
        lcl_exp_t cur;
        bit       in_req;
        int       cyc;
        in_req = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_req = 1'b0;
            end else if ((lcl_rd || lcl_wr) && !in_req) begin
                in_req = 1'b1; cyc = 1;
                if (lcl_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL lcl_unexpected: got request addr=%h expected none", lcl_addr);
                    cur.dur = 0;
                end else begin
                    cur = lcl_q.pop_front();
                    check("lcl_wr", lcl_wr, cur.wr);
                    check("lcl_rd", lcl_rd, !cur.wr);
                    check("lcl_addr", lcl_addr, cur.addr);
                    check("lcl_burst", lcl_burst, cur.burst);
                    check("ad_oe_access", AD_oe, !cur.wr);
                    if (cur.wr) check("lcl_wdata", lcl_wdata, cur.wdata);
                    $display("lcl: wr=%b rd=%b addr=%h wdata=%h burst=%b", lcl_wr, lcl_rd,
                             lcl_addr, lcl_wdata, lcl_burst);
                end
            end else if ((lcl_rd || lcl_wr) && in_req) begin
                cyc++;
            end else if (in_req) begin
                in_req = 1'b0;
                if (cur.dur != 0) check("lcl_req_cycles", cyc, cur.dur);
            end
        end
    end

    initial begin : mon_cmd
        logic [7:0] c;
        forever begin
            @(negedge clk);
            if (!rst && cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got cmd_valid code=%h expected none", cmd_code);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_code", cmd_code, c);
                    $display("cmd: code=%h", cmd_code);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1; set_idle(); typ = 1'b0; AAH8 = 8'h00; AD_in = 8'h00; irq_src = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_rdy_n", rdy_n, 1'b1);
        check("rst_err_n", err_n, 1'b1);
        check("rst_irq_n", irq_n, 1'b1);
        check("rst_ad_out", AD_out, 8'h00);
        check("rst_ad_oe", AD_oe, 1'b0);
        check("rst_lcl_wr", lcl_wr, 1'b0);
        check("rst_lcl_rd", lcl_rd, 1'b0);
        check("rst_lcl_addr", lcl_addr, 32'h0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // Single read, ack on the third request cycle.
        ack_delay = 3; rdata_cfg = 8'hA5;
        addr_frame(8'h12, 8'h34);
        dummy_frame();
        beat(1'b0, 8'h56, 8'h00, 1'b0, 32'h00123456, 3, 1'b1, 8'hA5);
        end_access();

        // Single write, immediate ack.
        ack_delay = 1;
        addr_frame(8'h00, 8'hFF);
        dummy_frame();
        beat(1'b1, 8'h10, 8'h5A, 1'b0, 32'h0000FF10, 1, 1'b1, 8'h00);
        end_access();

        // Page load via command 00, then a non-zero command that must not touch the page.
        cmd_frame(8'h00, 8'h80);
        addr_frame(8'h00, 8'h00);
        dummy_frame();
        beat(1'b1, 8'h01, 8'h77, 1'b0, 32'h80000001, 1, 1'b1, 8'h00);
        end_access();
        cmd_frame(8'h3C, 8'h55);
        @(negedge clk);

        // Four-beat burst write; beat 2 reports a local error.
        ack_delay = 2;
        addr_frame(8'hAB, 8'hCD);
        dummy_frame();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            ack_err = (i == 2);
            beat(1'b1, lo, 8'h10 + lo, 1'b1, {8'h80, 8'hAB, 8'hCD, lo}, 2, (i == 2) ? 1'b0 : 1'b1, 8'h00);
        end
        ack_err = 1'b0;
        end_access();
        cmd_frame(8'h00, 8'h00);
        @(negedge clk);

        // Read timeout with no ack, then ack+err landing on the timeout cycle.
        ack_delay = 0;
        addr_frame(8'h00, 8'h42);
        dummy_frame();
        beat(1'b0, 8'h07, 8'h00, 1'b0, 32'h00004207, 64, 1'b0, 8'hFF);
        end_access();
        ack_delay = 64; ack_err = 1'b1; rdata_cfg = 8'h3C;
        addr_frame(8'h00, 8'h42);
        dummy_frame();
        beat(1'b0, 8'h08, 8'h00, 1'b0, 32'h00004208, 64, 1'b0, 8'h3C);
        end_access();
        ack_err = 1'b0;

        // Reset in the middle of a read access.
        ack_delay = 0;
        addr_frame(8'h00, 8'h99);
        dummy_frame();
        cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'h11; typ = 1'b0;
        push_lcl(1'b0, 32'h00009911, 8'h00, 1'b0, 0);
        repeat (6) @(negedge clk);
        check("rd_before_rst", lcl_rd, 1'b1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_mid_lcl_rd", lcl_rd, 1'b0);
        check("rst_mid_rdy_n", rdy_n, 1'b1);
        check("rst_mid_ad_oe", AD_oe, 1'b0);
        set_idle();
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        set_idle();
        @(negedge clk);
        cmd_frame(8'h5E, 8'h00);
        @(negedge clk);

        // Interrupt forwarding with one cycle of latency.
        irq_src = 4'b0100;
        check("irq_n_before", irq_n, 1'b1);
        @(negedge clk);
        check("irq_n_asserted", irq_n, 1'b0);
        irq_src = 4'b0000;
        @(negedge clk);
        check("irq_n_released", irq_n, 1'b1);

        repeat (5) @(negedge clk);
        check("rdy_q_empty", rdy_q.size(), 0);
        check("lcl_q_empty", lcl_q.size(), 0);
        check("cmd_q_empty", cmd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
